// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: round-robin arbiter over 2**N requesters with registered one-hot grant and binary index.
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester request level, bit i = requester i
//   gnt      registered one-hot grant, zero when idle
//   gnt_idx  index of the current or last grantee
//   busy     high while a grant is active (OR of gnt)
//   timeout  one-cycle pulse when a grant is revoked for exceeding MAX_HOLD cycles
// Optional hold timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_arbiter_onehot #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    output logic [2**N-1:0]   gnt,
    output logic [N-1:0]      gnt_idx,
    output logic              busy,
    output logic              timeout
);
    localparam int W = 2**N;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] gnt_q, gnt_d;
    logic [N-1:0] idx_q, idx_d, ptr_q, ptr_d, off;
    logic         to_q, to_d, expire;
    // Lowest offset from ptr with a request; N-bit addition gives the modulo wrap.
    always_comb begin
        off = '0;
        for (int k = W - 1; k >= 0; k--)
            if (req[ptr_q + N'(k)]) off = N'(k);
    end
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] cnt_q, cnt_d;
    // cnt is 0 in the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle.
    assign cnt_d  = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
    assign expire = cnt_q == CW'(MAX_HOLD - 1);
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
`else
    // MAX_HOLD is always >= 2, so this folds to 0.
    assign expire = MAX_HOLD < 0;
`endif
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                idx_d   = ptr_q + off;
                gnt_d   = W'(1) << idx_d;
                ptr_d   = idx_d + 1'b1;
            end
        end else if (!req[idx_q] || expire) begin
            state_d = IDLE;
            gnt_d   = '0;
            // A normal release wins over the limit, so only a still-held request pulses timeout.
            to_d    = req[idx_q];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
        end
    end
    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = state_q == GRANT;
    assign timeout = to_q;
endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// tb_rr_arbiter_onehot: directed and random checks of rr_arbiter_onehot (N=2, MAX_HOLD=4) against a behavioural model.
module tb_rr_arbiter_onehot;
    localparam int N = 2;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy, timeout;
    int vecs = 0, errs = 0;
    bit m_act, m_to;
    int m_idx, m_ptr, m_hold;
    rr_arbiter_onehot #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cycle(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        if (r) begin
            m_act = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_act) begin
            m_to = 0;
            for (int k = 0; k < 4; k++)
                if (rq[(m_ptr + k) % 4]) begin
                    m_idx  = (m_ptr + k) % 4;
                    m_ptr  = (m_idx + 1) % 4;
                    m_act  = 1;
                    m_hold = 1;
                    break;
                end
        end else if (!rq[m_idx]) begin
            m_act = 0; m_to = 0;
        end else if (TO_EN && m_hold == MAX_HOLD) begin
            m_act = 0; m_to = 1;
        end else begin
            m_hold++; m_to = 0;
        end
        #1;
        check("gnt", gnt, m_act ? 32'(1 << m_idx) : 32'd0);
        check("gnt_idx", gnt_idx, m_idx);
        check("busy", busy, m_act);
        check("timeout", timeout, m_to);
    endtask
    initial begin
        logic [3:0] rq;
        int order[5] = '{0, 1, 2, 3, 0};
        cycle(1, 0);
        cycle(1, 0);
        check("rst_gnt", gnt, 0);
        check("rst_idx", gnt_idx, 0);
        cycle(0, 4'b0100);
        check("single_gnt", gnt, 4'b0100);
        check("single_idx", gnt_idx, 2);
        cycle(1, 0);
        foreach (order[i]) begin
            cycle(0, 4'b1111);
            check("rr_order", gnt_idx, order[i]);
            cycle(0, 4'b1111);
            cycle(0, 4'b1111 & ~(4'b1 << order[i]));
            check("rr_dead", gnt, 0);
        end
        cycle(1, 0);
        cycle(0, 4'b1000);
        cycle(0, 4'b0000);
        cycle(0, 4'b1001);
        check("wrap_to_0", gnt_idx, 0);
        cycle(0, 4'b0000);
        cycle(0, 4'b1000);
        check("wrap_then_3", gnt_idx, 3);
        cycle(1, 0);
        cycle(0, 4'b0010);
        repeat (5) cycle(0, {1'($urandom), 2'b01, 1'($urandom)});
        cycle(1, 0);
        cycle(0, 4'b0100);
        cycle(1, 4'b0100);
        check("midrst_gnt", gnt, 0);
        check("midrst_to", timeout, 0);
        cycle(0, 4'b0110);
        check("midrst_next", gnt_idx, 1);
        cycle(1, 0);
        repeat (12) cycle(0, 4'b0001);
        repeat (600) begin
            rq = 4'($urandom);
            if (m_act && $urandom_range(0, 3) != 0) rq[m_idx] = 1'b1;
            cycle($urandom_range(0, 49) == 0, rq);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
